// File: rtl/dma_channel_ctrl.sv
// dma_channel_ctrl: splits a mem-to-mem copy into SEG_BYTES segments and sequences Read/Write_Master
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   i_start, i_abort                   command pulse (IDLE only), abort request (while busy)
//   i_src_addr, i_dst_addr, i_total_len command: byte addresses and byte length
//   o_rd_start/o_rd_addr/o_rd_len      segment launch to Read_Master
//   i_rd_done, i_rd_err                Read_Master segment complete / error pulses
//   o_wr_start/o_wr_addr/o_wr_len      segment launch to Write_Master
//   i_wr_done, i_wr_err                Write_Master segment complete / error pulses
//   o_busy, o_done                     command in progress, one-cycle completion pulse
//   o_error, o_aborted                 sticky status until next accepted command
//   o_bytes_done                       bytes in fully completed segments
module dma_channel_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int SEG_BYTES  = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [LEN_WIDTH-1:0]  i_total_len,
    output logic                  o_rd_start,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [LEN_WIDTH-1:0]  o_rd_len,
    input  logic                  i_rd_done,
    input  logic                  i_rd_err,
    output logic                  o_wr_start,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [LEN_WIDTH-1:0]  o_wr_len,
    input  logic                  i_wr_done,
    input  logic                  i_wr_err,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_aborted,
    output logic [LEN_WIDTH-1:0]  o_bytes_done
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
    localparam logic [LEN_WIDTH-1:0]  SEG   = LEN_WIDTH'(SEG_BYTES);
    localparam logic [LEN_WIDTH-1:0]  LMASK = ~LEN_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(3);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, rem_q, rem_d, bytes_q, bytes_d;
    logic                  rd_seen_q, rd_seen_d, wr_seen_q, wr_seen_d;
    logic                  err_q, err_d, abt_q, abt_d, error_q, error_d, aborted_q, aborted_d;
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        len_d     = len_q;
        rem_d     = rem_q;
        bytes_d   = bytes_q;
        rd_seen_d = rd_seen_q;
        wr_seen_d = wr_seen_q;
        err_d     = err_q;
        abt_d     = abt_q;
        error_d   = error_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: if (i_start) begin
                error_d   = 1'b0;
                aborted_d = 1'b0;
                bytes_d   = '0;
                err_d     = 1'b0;
                abt_d     = 1'b0;
                rem_d     = i_total_len & LMASK;
                if (rem_d == '0) begin
                    state_d = DONE;
                end else begin
                    rd_addr_d = i_src_addr & AMASK;
                    wr_addr_d = i_dst_addr & AMASK;
                    len_d     = (rem_d > SEG) ? SEG : rem_d;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                rd_seen_d = 1'b0;
                wr_seen_d = 1'b0;
                abt_d     = abt_q | i_abort;
                state_d   = WAIT;
            end
            WAIT: begin
                rd_seen_d = rd_seen_q | i_rd_done;
                wr_seen_d = wr_seen_q | i_wr_done;
                err_d     = err_q | i_rd_err | i_wr_err;
                abt_d     = abt_q | i_abort;
                // Segment boundary: abort/error only stop the command here, never mid-segment.
                if (rd_seen_d && wr_seen_d) begin
                    rem_d   = rem_q - len_q;
                    bytes_d = bytes_q + len_q;
                    if (rem_d == '0 || err_d || abt_d) begin
                        error_d   = err_d;
                        aborted_d = abt_d;
                        state_d   = DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_WIDTH'(len_q);
                        wr_addr_d = wr_addr_q + ADDR_WIDTH'(len_q);
                        len_d     = (rem_d > SEG) ? SEG : rem_d;
                        state_d   = LAUNCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            bytes_q   <= '0;
            rd_seen_q <= 1'b0;
            wr_seen_q <= 1'b0;
            err_q     <= 1'b0;
            abt_q     <= 1'b0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            bytes_q   <= bytes_d;
            rd_seen_q <= rd_seen_d;
            wr_seen_q <= wr_seen_d;
            err_q     <= err_d;
            abt_q     <= abt_d;
            error_q   <= error_d;
            aborted_q <= aborted_d;
        end
    end
    assign o_rd_start   = state_q == LAUNCH;
    assign o_wr_start   = state_q == LAUNCH;
    assign o_rd_addr    = rd_addr_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_rd_len     = len_q;
    assign o_wr_len     = len_q;
    assign o_busy       = state_q == LAUNCH || state_q == WAIT;
    assign o_done       = state_q == DONE;
    assign o_error      = error_q;
    assign o_aborted    = aborted_q;
    assign o_bytes_done = bytes_q;
endmodule

// File: tb/tb_dma_channel_ctrl.sv
// tb_dma_channel_ctrl: scoreboard bench for dma_channel_ctrl
module tb_dma_channel_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        i_start = 0, i_abort = 0, i_rd_done = 0, i_rd_err = 0, i_wr_done = 0, i_wr_err = 0;
    logic [31:0] i_src_addr = 0, i_dst_addr = 0, i_total_len = 0;
    logic        o_rd_start, o_wr_start, o_busy, o_done, o_error, o_aborted;
    logic [31:0] o_rd_addr, o_rd_len, o_wr_addr, o_wr_len, o_bytes_done;
    typedef struct packed {logic [31:0] src; logic [31:0] dst; logic [31:0] len;} seg_t;
    seg_t q[$];
    int n_chk = 0, n_fail = 0;

    dma_channel_ctrl dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
        .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_total_len(i_total_len),
        .o_rd_start(o_rd_start), .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len),
        .i_rd_done(i_rd_done), .i_rd_err(i_rd_err),
        .o_wr_start(o_wr_start), .o_wr_addr(o_wr_addr), .o_wr_len(o_wr_len),
        .i_wr_done(i_wr_done), .i_wr_err(i_wr_err),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_aborted(o_aborted),
        .o_bytes_done(o_bytes_done)
    );

    always #5 clk = ~clk;

    // Every launch seen mid-cycle must match the oldest expected segment.
    always @(negedge clk) begin
        if (o_rd_start === 1'b1 || o_wr_start === 1'b1) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL launch_unexpected: got rd_start=%b wr_start=%b, required no launch", o_rd_start, o_wr_start);
            end else begin
                seg_t s;
                s = q.pop_front();
                if (!(o_rd_start === 1'b1 && o_wr_start === 1'b1 && o_rd_addr === s.src && o_wr_addr === s.dst
                      && o_rd_len === s.len && o_wr_len === s.len)) begin
                    n_fail++;
                    $display("FAIL launch_fields: got st=%b%b rd=%h/%0d wr=%h/%0d, required st=11 rd=%h/%0d wr=%h/%0d",
                             o_rd_start, o_wr_start, o_rd_addr, o_rd_len, o_wr_addr, o_wr_len, s.src, s.len, s.dst, s.len);
                end
            end
        end
    end

    task automatic push_segs(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len, input int n);
        logic [31:0] s, d, r, l;
        s = src & ~32'd3; d = dst & ~32'd3; r = len & ~32'd3;
        for (int i = 0; i < n && r != 0; i++) begin
            l = (r > 32'd256) ? 32'd256 : r;
            q.push_back('{src: s, dst: d, len: l});
            s += l; d += l; r -= l;
        end
    endtask

    task automatic cmd(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
        i_src_addr = src; i_dst_addr = dst; i_total_len = len; i_start = 1;
        @(negedge clk);
        i_start = 0;
    endtask

    task automatic pulse(input bit rd, input bit wr);
        i_rd_done = rd; i_wr_done = wr;
        @(negedge clk);
        i_rd_done = 0; i_wr_done = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({o_rd_start, o_wr_start, o_busy, o_done, o_error, o_aborted} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b, required 000000", {o_rd_start, o_wr_start, o_busy, o_done, o_error, o_aborted});
        end
        n_chk++;
        if ({o_rd_addr, o_rd_len, o_wr_addr, o_wr_len, o_bytes_done} !== 160'b0) begin
            n_fail++; $display("FAIL reset_buses: got %h %h %h %h %h, required all 0", o_rd_addr, o_rd_len, o_wr_addr, o_wr_len, o_bytes_done);
        end
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        push_segs(32'h1000_0000, 32'hC000_0000, 256, 1);
        cmd(32'h1000_0000, 32'hC000_0000, 256);
        n_chk++;
        if (o_rd_start !== 1 || o_busy !== 1) begin n_fail++; $display("FAIL single_launch: got start=%b busy=%b, required 1 1", o_rd_start, o_busy); end
        @(negedge clk);
        pulse(1, 0);
        n_chk++;
        if (o_done !== 0 || o_busy !== 1) begin n_fail++; $display("FAIL single_half: got done=%b busy=%b, required 0 1", o_done, o_busy); end
        pulse(0, 1);
        n_chk++;
        if (o_done !== 1 || o_busy !== 0 || o_bytes_done !== 256 || o_error !== 0 || o_aborted !== 0) begin
            n_fail++; $display("FAIL single_done: got done=%b busy=%b bytes=%0d err=%b abt=%b, required 1 0 256 0 0", o_done, o_busy, o_bytes_done, o_error, o_aborted);
        end
        @(negedge clk);
        n_chk++;
        if (o_done !== 0 || o_rd_addr !== 32'h1000_0000 || o_wr_addr !== 32'hC000_0000) begin
            n_fail++; $display("FAIL single_after: got done=%b rd=%h wr=%h, required 0 10000000 c0000000", o_done, o_rd_addr, o_wr_addr);
        end
    endtask

    task automatic test_multi();
        push_segs(32'h2000_0000, 32'h3000_0003, 602, 3);
        cmd(32'h2000_0000, 32'h3000_0003, 602);
        n_chk++;
        if (o_rd_start !== 1) begin n_fail++; $display("FAIL multi_launch0: got %b, required 1", o_rd_start); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pulse(1, 1);
            n_chk++;
            if (i < 2 && (o_rd_start !== 1 || o_done !== 0)) begin
                n_fail++; $display("FAIL multi_relaunch%0d: got start=%b done=%b, required 1 0", i, o_rd_start, o_done);
            end else if (i == 2 && (o_done !== 1 || o_bytes_done !== 600)) begin
                n_fail++; $display("FAIL multi_done: got done=%b bytes=%0d, required 1 600", o_done, o_bytes_done);
            end
        end
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin n_fail++; $display("FAIL multi_pending: got %0d launches left, required 0", q.size()); end
    endtask

    task automatic test_ordering();
        push_segs(32'h0000_1000, 32'h0000_8000, 768, 3);
        cmd(32'h0000_1000, 32'h0000_8000, 768);
        @(negedge clk);
        pulse(0, 1);
        n_chk++;
        if (o_rd_start !== 0) begin n_fail++; $display("FAIL order_wr_only: got start=%b, required 0", o_rd_start); end
        @(negedge clk);
        pulse(1, 0);
        n_chk++;
        if (o_rd_start !== 1) begin n_fail++; $display("FAIL order_wr_then_rd: got start=%b, required 1", o_rd_start); end
        @(negedge clk);
        pulse(1, 1);
        n_chk++;
        if (o_rd_start !== 1) begin n_fail++; $display("FAIL order_same: got start=%b, required 1", o_rd_start); end
        @(negedge clk);
        pulse(1, 0);
        n_chk++;
        if (o_done !== 0) begin n_fail++; $display("FAIL order_rd_only: got done=%b, required 0", o_done); end
        pulse(0, 1);
        n_chk++;
        if (o_done !== 1 || o_bytes_done !== 768) begin n_fail++; $display("FAIL order_done: got done=%b bytes=%0d, required 1 768", o_done, o_bytes_done); end
        @(negedge clk);
    endtask

    task automatic test_zero_and_back_to_back();
        cmd(32'h100, 32'h200, 0);
        n_chk++;
        if (o_done !== 1 || o_busy !== 0 || o_bytes_done !== 0) begin n_fail++; $display("FAIL zero_len: got done=%b busy=%b bytes=%0d, required 1 0 0", o_done, o_busy, o_bytes_done); end
        @(negedge clk);
        cmd(32'h100, 32'h200, 3);
        n_chk++;
        if (o_done !== 1 || o_bytes_done !== 0) begin n_fail++; $display("FAIL len3: got done=%b bytes=%0d, required 1 0", o_done, o_bytes_done); end
        @(negedge clk);
        push_segs(32'h0000_0400, 32'h0000_0800, 256, 1);
        cmd(32'h0000_0400, 32'h0000_0800, 256);
        n_chk++;
        if (o_rd_start !== 1) begin n_fail++; $display("FAIL back_to_back: got start=%b, required 1", o_rd_start); end
        @(negedge clk);
        cmd(32'h0000_9000, 32'h0000_A000, 512);
        repeat (2) @(negedge clk);
        pulse(1, 1);
        n_chk++;
        if (o_done !== 1 || o_bytes_done !== 256) begin n_fail++; $display("FAIL busy_start: got done=%b bytes=%0d, required 1 256", o_done, o_bytes_done); end
        @(negedge clk);
    endtask

    task automatic test_error();
        push_segs(32'h4000_0000, 32'h5000_0000, 1024, 1);
        cmd(32'h4000_0000, 32'h5000_0000, 1024);
        @(negedge clk);
        i_wr_err = 1;
        @(negedge clk);
        i_wr_err = 0;
        pulse(1, 1);
        n_chk++;
        if (o_done !== 1 || o_error !== 1 || o_aborted !== 0 || o_bytes_done !== 256 || o_rd_start !== 0) begin
            n_fail++; $display("FAIL error_done: got done=%b err=%b abt=%b bytes=%0d start=%b, required 1 1 0 256 0", o_done, o_error, o_aborted, o_bytes_done, o_rd_start);
        end
        @(negedge clk);
        n_chk++;
        if (o_error !== 1) begin n_fail++; $display("FAIL error_sticky: got %b, required 1", o_error); end
        cmd(32'h0, 32'h0, 0);
        n_chk++;
        if (o_done !== 1 || o_error !== 0) begin n_fail++; $display("FAIL error_clear: got done=%b err=%b, required 1 0", o_done, o_error); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        push_segs(32'h6000_0000, 32'h7000_0000, 1024, 2);
        cmd(32'h6000_0000, 32'h7000_0000, 1024);
        @(negedge clk);
        pulse(1, 1);
        @(negedge clk);
        i_abort = 1;
        @(negedge clk);
        i_abort = 0;
        n_chk++;
        if (o_busy !== 1 || o_done !== 0) begin n_fail++; $display("FAIL abort_hold: got busy=%b done=%b, required 1 0", o_busy, o_done); end
        pulse(1, 1);
        n_chk++;
        if (o_done !== 1 || o_aborted !== 1 || o_error !== 0 || o_bytes_done !== 512) begin
            n_fail++; $display("FAIL abort_done: got done=%b abt=%b err=%b bytes=%0d, required 1 1 0 512", o_done, o_aborted, o_error, o_bytes_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        push_segs(32'h0001_0000, 32'h0002_0000, 512, 1);
        cmd(32'h0001_0000, 32'h0002_0000, 512);
        @(negedge clk);
        reset_n = 0;
        #1;
        n_chk++;
        if ({o_rd_start, o_wr_start, o_busy, o_done, o_error, o_aborted} !== 6'b0 || {o_rd_addr, o_rd_len, o_wr_addr, o_wr_len, o_bytes_done} !== 160'b0) begin
            n_fail++; $display("FAIL reset_mid: got busy=%b rd=%h/%0d wr=%h bytes=%0d, required all 0", o_busy, o_rd_addr, o_rd_len, o_wr_addr, o_bytes_done);
        end
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        pulse(1, 1);
        n_chk++;
        if (o_done !== 0 || o_busy !== 0 || q.size() != 0) begin
            n_fail++; $display("FAIL reset_idle: got done=%b busy=%b pending=%0d, required 0 0 0", o_done, o_busy, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_ordering();
        test_zero_and_back_to_back();
        test_error();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dma_channel_ctrl.md
# dma_channel_ctrl

Sequencing controller for one DMA channel. Accepts a memory-to-memory copy command (source, destination, byte length), splits it into segments of at most SEG_BYTES, and drives the Read_Master and Write_Master start/address/length inputs for each segment. After each segment it waits for both masters' done pulses before launching the next. It sits between the register/command front end and the Read_Master → FIFO → Write_Master datapath, and reports completion, error and abort status.

## Interface

- ADDR_WIDTH, 32: address width of src/dst.
- LEN_WIDTH, 32: width of length and byte counters.
- SEG_BYTES, 256: maximum segment length in bytes. Power of two, multiple of 4, ≤ 4096. Matches the masters' burst/FIFO depth.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  command pulse; accepted only in IDLE.
- i_abort  in  1  abort request; sampled only while busy.
- i_src_addr  in  ADDR_WIDTH  source byte address.
- i_dst_addr  in  ADDR_WIDTH  destination byte address.
- i_total_len  in  LEN_WIDTH  transfer length in bytes.
- o_rd_start  out  1  one-cycle start pulse to Read_Master.
- o_rd_addr  out  ADDR_WIDTH  segment source address.
- o_rd_len  out  LEN_WIDTH  segment length in bytes.
- i_rd_done  in  1  Read_Master segment-complete pulse.
- i_rd_err  in  1  Read_Master RRESP error pulse.
- o_wr_start  out  1  one-cycle start pulse to Write_Master.
- o_wr_addr  out  ADDR_WIDTH  segment destination address.
- o_wr_len  out  LEN_WIDTH  segment length in bytes.
- i_wr_done  in  1  Write_Master o_write_done pulse.
- i_wr_err  in  1  Write_Master BRESP error pulse.
- o_busy  out  1  command in progress.
- o_done  out  1  one-cycle command-complete pulse.
- o_error  out  1  sticky: a master reported an error.
- o_aborted  out  1  sticky: command ended by abort.
- o_bytes_done  out  LEN_WIDTH  bytes in fully completed segments.

## Operation

- States: IDLE, LAUNCH, WAIT, DONE.
- **IDLE**
  - On i_start, latch both addresses with bits [1:0] forced to 0, and set rem = i_total_len with bits [1:0] forced to 0.
  - Clear o_error, o_aborted, o_bytes_done and the abort/error latches.
  - If rem == 0, go to DONE. Otherwise, on the same edge, register seg = min(rem, SEG_BYTES) into o_rd_len/o_wr_len, drive the addresses onto o_rd_addr/o_wr_addr, and go to LAUNCH.
- **LAUNCH**
  - o_rd_start = o_wr_start = 1 for exactly this cycle.
  - Clear the rd_seen/wr_seen flags, then go to WAIT.
- **WAIT**
  - Set rd_seen on i_rd_done and wr_seen on i_wr_done. Pulses may arrive in either order or in the same cycle.
  - i_rd_err or i_wr_err sets the error latch. i_abort sets the abort latch.
  - When both flags are set (counting a done pulse arriving in the current cycle): rem -= seg, both addresses += seg, o_bytes_done += seg.
  - If rem == 0, or the error latch is set, or the abort latch is set: go to DONE.
  - Otherwise register the next segment's addr/len outputs and go to LAUNCH.
- **DONE**
  - o_done = 1 for one cycle.
  - o_error and o_aborted take their latched values and hold them until the next accepted i_start. Then go to IDLE.
- A segment already launched is never cut short: abort and error take effect at the segment boundary.
- o_busy = 1 in LAUNCH and WAIT. i_start is ignored while busy or in DONE.
- Done or error pulses received in IDLE/DONE are ignored.
- Arithmetic is modulo 2^ADDR_WIDTH; address wrap-around is not flagged.
- Reset, including reset mid-transfer: state IDLE, all outputs 0. The masters share reset_n.

## Timing

- Reset values: all outputs 0, including the addr/len buses.
- i_start sampled at edge E: start pulses are high during the cycle after E, and addr/len are valid from that same cycle.
- addr/len buses stay stable until the next LAUNCH.
- Last required done sampled at edge E:
  - next segment's start pulses are high in the cycle after E; or
  - o_done is high in the cycle after E and o_busy is low from that cycle.
- Zero length: o_done is high in the cycle after the i_start edge, with no start pulses.
- Back-to-back: i_start accepted in the cycle after o_done.

## Test plan

- len=256, src=0x1000_0000, dst=0xC000_0000 → one rd/wr start pair with len=256; o_done one cycle after the later done; o_bytes_done=256; o_error=o_aborted=0.
- len=600 → three pairs with len 256/256/88 (88 = 600−512, a multiple of 4); addresses advance by 0x100 per segment; each launch comes one cycle after the later done; a single o_done.
- Ordering: wr_done before rd_done, then the same cycle, then rd_done before wr_done → next launch only after both, one cycle after the later pulse, in all three cases.
- len=0 and len=3 → no start pulses; o_done in the cycle after start; o_bytes_done=0. i_start during busy → ignored, no extra pulses.
- len=1024 with i_wr_err during segment 1 → no second launch; o_done with o_error=1; o_bytes_done=256. The next i_start clears o_error.
- len=1024 with i_abort during segment 2 → segment 2 completes; o_done with o_aborted=1; o_bytes_done=512. reset_n low mid-segment → all outputs 0, state IDLE.
